// File: rtl/sync_fifo_rd_ctrl_pkg.sv
// Shared types and build-time defaults for the synchronous FIFO read side.
// FIFO_DEPTH / DATA_WIDTH macros may be predefined by the build to override defaults.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package sync_fifo_rd_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = `FIFO_DEPTH;
    localparam int unsigned DATA_WIDTH_DEF = `DATA_WIDTH;
    localparam int unsigned CNT_WIDTH      = 32;

    // Output buffer occupancy: out reg only, or out reg plus skid reg.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input occ_e occ);
        return 2'(occ);
    endfunction

endpackage

// File: rtl/sync_fifo_out_skid.sv
// Two-entry registered output buffer (out reg + skid reg) with valid/ready handshake.
// Capacity is guaranteed by the issuer; a return never arrives while both entries are held without a pop.
module sync_fifo_out_skid
    import sync_fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  i_ready_m,
    output occ_e                  occ,
    output logic                  o_valid_m,
    output logic [DATA_WIDTH-1:0] o_data_m
);

    occ_e                  occ_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  pop_c;

    assign pop_c = (occ_q != OCC_EMPTY) & i_ready_m;

    // Occupancy FSM; a return lands in the out reg whenever it is free after this edge's pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= OCC_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (wr_vld) begin
                        out_q <= wr_data;
                        occ_q <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (wr_vld && pop_c) begin
                        out_q <= wr_data;
                    end else if (wr_vld) begin
                        skid_q <= wr_data;
                        occ_q  <= OCC_TWO;
                    end else if (pop_c) begin
                        occ_q <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop_c) begin
                        out_q <= skid_q;
                        if (wr_vld) begin
                            skid_q <= wr_data;
                        end else begin
                            occ_q <= OCC_ONE;
                        end
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign occ       = occ_q;
    assign o_valid_m = (occ_q != OCC_EMPTY);
    assign o_data_m  = out_q;

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller of the synchronous FIFO: read pointer, memory read issue and output buffering.
// Optional build macro SYNC_FIFO_RD_CNT_EN adds a free-running 32-bit pop counter on o_rd_cnt.
module sync_fifo_rd_ctrl
    import sync_fifo_rd_ctrl_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   i_wr_addr,
    output logic [ADDR_WIDTH:0]   o_rd_addr,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [DATA_WIDTH-1:0] o_data_m,
    output logic                  o_mem_empty,
    output logic [ADDR_WIDTH+1:0] o_level
`ifdef SYNC_FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_rd_cnt
`endif
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned LVL_W = ADDR_WIDTH + 2;

    logic [PTR_W-1:0] rd_addr_q;
    logic             infl_q;
    logic [PTR_W-1:0] mcnt_c;
    logic [2:0]       budget_c;
    logic             pop_c;
    logic             issue_c;
    occ_e             occ;

    assign mcnt_c   = i_wr_addr - rd_addr_q;
    assign pop_c    = o_valid_m & i_ready_m;
    assign budget_c = 3'(occ_count(occ)) + 3'(infl_q);
    // Issue only if buffered + in-flight words, after this pop, leave room for one more.
    assign issue_c  = (mcnt_c != '0) && (budget_c <= (3'd1 + 3'(pop_c)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q <= '0;
            infl_q    <= 1'b0;
        end else begin
            infl_q <= issue_c;
            if (issue_c) begin
                rd_addr_q <= rd_addr_q + PTR_W'(1);
            end
        end
    end

    sync_fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_vld    (infl_q),
        .wr_data   (i_mem_rd_data),
        .i_ready_m (i_ready_m),
        .occ       (occ),
        .o_valid_m (o_valid_m),
        .o_data_m  (o_data_m)
    );

    assign o_rd_addr     = rd_addr_q;
    assign o_mem_rd_en   = issue_c;
    assign o_mem_rd_addr = rd_addr_q[ADDR_WIDTH-1:0];
    assign o_mem_empty   = (i_wr_addr == rd_addr_q);
    assign o_level       = LVL_W'(mcnt_c) + LVL_W'(infl_q) + LVL_W'(occ_count(occ));

`ifdef SYNC_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] rd_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
        end else if (pop_c) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign o_rd_cnt = rd_cnt_q;
`endif

endmodule
